// File: rtl/reg_scoreboard_if.sv
// Issue, write-back and status signals between the issue stage and the register scoreboard.
interface reg_scoreboard_if #(
  parameter int TOT_W = 7
);
  logic             issue_valid;
  logic [4:0]       issue_rs1;
  logic [4:0]       issue_rs2;
  logic [4:0]       issue_rd;
  logic             issue_rd_en;
  logic             issue_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             flush;
  logic             busy_rs1;
  logic             busy_rs2;
  logic [TOT_W-1:0] pending_total;
  logic             wb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en,
    output wb_valid, wb_rd, flush,
    input  issue_ready, busy_rs1, busy_rs2, pending_total, wb_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en,
    input  wb_valid, wb_rd, flush,
    output issue_ready, busy_rs1, busy_rs2, pending_total, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Read-side interlock: counts in-flight writes per register and stalls issue
// while a source operand still has a write pending.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int TOT_W    = 7
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:1][CNT_W-1:0] cnt_q, cnt_d;
  logic [TOT_W-1:0]               total_q, total_d;
  logic                           wb_err_q, wb_err_d;

  logic sat_rd, accept, inc, dec, wb_zero;
  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;

  // Register 0 has no counter and always reads as idle.
  function automatic logic [CNT_W-1:0] cnt_of(
    input logic [NUM_REGS-1:1][CNT_W-1:0] cnt,
    input logic [IDX_W-1:0]               idx
  );
    if (idx == '0) return '0;
    return cnt[idx];
  endfunction

  always_comb begin
    cnt_rs1 = cnt_of(cnt_q, sb.issue_rs1);
    cnt_rs2 = cnt_of(cnt_q, sb.issue_rs2);
    cnt_rd  = cnt_of(cnt_q, sb.issue_rd);
    cnt_wb  = cnt_of(cnt_q, sb.wb_rd);

    sb.busy_rs1    = (cnt_rs1 != '0);
    sb.busy_rs2    = (cnt_rs2 != '0);
    sat_rd         = sb.issue_rd_en && (sb.issue_rd != '0) && (cnt_rd == CNT_MAX);
    sb.issue_ready = !(sb.busy_rs1 || sb.busy_rs2 || sat_rd) && !sb.flush;
    accept         = sb.issue_valid && sb.issue_ready;

    // accept already excludes flush and a saturated destination
    inc     = accept && sb.issue_rd_en && (sb.issue_rd != '0);
    dec     = !sb.flush && sb.wb_valid && (sb.wb_rd != '0) && (cnt_wb != '0);
    wb_zero = !sb.flush && sb.wb_valid && (sb.wb_rd != '0) && (cnt_wb == '0);

    sb.pending_total = total_q;
    sb.wb_err        = wb_err_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (sb.flush) begin
        cnt_d[r] = '0;
      end else begin
        // An issue and a retire to the same register cancel out.
        if ((inc && sb.issue_rd == IDX_W'(r)) && !(dec && sb.wb_rd == IDX_W'(r)))
          cnt_d[r] = cnt_q[r] + 1'b1;
        else if (!(inc && sb.issue_rd == IDX_W'(r)) && (dec && sb.wb_rd == IDX_W'(r)))
          cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end

    if (sb.flush)
      total_d = '0;
    else
      total_d = total_q + TOT_W'(inc) - TOT_W'(dec);

    wb_err_d = wb_err_q || wb_zero;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      total_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      total_q  <= total_d;
      wb_err_q <= wb_err_d;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: stall, saturation, cancel, error, flush, async reset.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  reg_scoreboard_if #(.TOT_W(7)) sb_if ();

  reg_scoreboard #(.NUM_REGS(32), .CNT_W(2), .TOT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.issue_valid = 0; sb_if.issue_rs1 = 0; sb_if.issue_rs2 = 0;
    sb_if.issue_rd = 0; sb_if.issue_rd_en = 0;
    sb_if.wb_valid = 0; sb_if.wb_rd = 0; sb_if.flush = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    sb_if.issue_valid = 1; sb_if.issue_rs1 = 0; sb_if.issue_rs2 = 0;
    sb_if.issue_rd = rd; sb_if.issue_rd_en = 1;
  endtask

  initial begin
    idle();
    // Reset held for two edges
    tick(); tick();
    chk("rst_busy1", int'(sb_if.busy_rs1), 0);
    chk("rst_busy2", int'(sb_if.busy_rs2), 0);
    chk("rst_total", int'(sb_if.pending_total), 0);
    chk("rst_err", int'(sb_if.wb_err), 0);
    rst = 1;
    sb_if.issue_valid = 1;
    #1 chk("idle_ready", int'(sb_if.issue_ready), 1);

    // RAW stall on r5
    issue(5);
    #1 chk("raw_issue_ready", int'(sb_if.issue_ready), 1);
    tick();
    sb_if.issue_rd_en = 0; sb_if.issue_rd = 0;
    sb_if.issue_rs1 = 5; sb_if.issue_rs2 = 5;
    #1;
    chk("raw_busy1", int'(sb_if.busy_rs1), 1);
    chk("raw_busy2", int'(sb_if.busy_rs2), 1);
    chk("raw_ready", int'(sb_if.issue_ready), 0);
    chk("raw_total", int'(sb_if.pending_total), 1);
    tick(); tick();
    sb_if.wb_valid = 1; sb_if.wb_rd = 5;
    #1 chk("raw_no_bypass", int'(sb_if.busy_rs1), 1);
    tick();
    sb_if.wb_valid = 0; sb_if.wb_rd = 0;
    #1;
    chk("raw_clear_busy", int'(sb_if.busy_rs1), 0);
    chk("raw_clear_ready", int'(sb_if.issue_ready), 1);
    chk("raw_clear_total", int'(sb_if.pending_total), 0);
    idle();

    // Saturation on r7
    issue(7);
    tick(); tick(); tick();
    chk("sat_total3", int'(sb_if.pending_total), 3);
    chk("sat_ready", int'(sb_if.issue_ready), 0);
    sb_if.issue_valid = 0;
    #1 chk("sat_ready_novalid", int'(sb_if.issue_ready), 0);
    sb_if.issue_valid = 1;
    tick();
    chk("sat_no_overflow", int'(sb_if.pending_total), 3);
    sb_if.wb_valid = 1; sb_if.wb_rd = 7;
    #1 chk("sat_wb_ready_same", int'(sb_if.issue_ready), 0);
    tick();
    sb_if.wb_valid = 0; sb_if.wb_rd = 0;
    #1;
    chk("sat_wb_ready_next", int'(sb_if.issue_ready), 1);
    chk("sat_wb_total", int'(sb_if.pending_total), 2);
    idle();

    // Simultaneous issue and write-back on r9
    issue(9);
    tick();
    chk("sim_total_pre", int'(sb_if.pending_total), 3);
    sb_if.wb_valid = 1; sb_if.wb_rd = 9;
    tick();
    chk("sim_total_same", int'(sb_if.pending_total), 3);
    idle();
    sb_if.issue_rs1 = 9;
    #1 chk("sim_busy9", int'(sb_if.busy_rs1), 1);
    sb_if.wb_valid = 1; sb_if.wb_rd = 9;
    tick();
    sb_if.wb_valid = 0;
    #1;
    chk("sim_cnt9_was1", int'(sb_if.busy_rs1), 0);
    chk("sim_total_post", int'(sb_if.pending_total), 2);
    idle();
    issue(0);
    sb_if.wb_valid = 1; sb_if.wb_rd = 0;
    tick();
    chk("zero_total", int'(sb_if.pending_total), 2);
    chk("zero_err", int'(sb_if.wb_err), 0);
    idle();

    // Write-back underflow sets the sticky error
    sb_if.wb_valid = 1; sb_if.wb_rd = 12;
    tick();
    chk("err_set", int'(sb_if.wb_err), 1);
    chk("err_total", int'(sb_if.pending_total), 2);
    issue(13);
    sb_if.wb_valid = 1; sb_if.wb_rd = 13;
    tick();
    chk("err_inc_wins", int'(sb_if.pending_total), 3);
    idle();

    // Flush with pending r3 and r4
    issue(3); tick();
    issue(4); tick();
    chk("fl_total_pre", int'(sb_if.pending_total), 5);
    idle();
    sb_if.flush = 1; sb_if.wb_valid = 1; sb_if.wb_rd = 3; sb_if.issue_valid = 1;
    #1 chk("fl_ready", int'(sb_if.issue_ready), 0);
    tick();
    idle();
    sb_if.issue_rs1 = 3; sb_if.issue_rs2 = 4;
    #1;
    chk("fl_total", int'(sb_if.pending_total), 0);
    chk("fl_err_sticky", int'(sb_if.wb_err), 1);
    chk("fl_busy3", int'(sb_if.busy_rs1), 0);
    chk("fl_busy4", int'(sb_if.busy_rs2), 0);
    idle();

    // Asynchronous reset between edges
    issue(1); tick();
    issue(2); tick();
    issue(3); tick();
    issue(4); tick();
    idle();
    sb_if.issue_rs1 = 1;
    #1;
    chk("ar_total_pre", int'(sb_if.pending_total), 4);
    chk("ar_busy_pre", int'(sb_if.busy_rs1), 1);
    #1 rst = 0;
    #1;
    chk("ar_total", int'(sb_if.pending_total), 0);
    chk("ar_busy", int'(sb_if.busy_rs1), 0);
    chk("ar_err", int'(sb_if.wb_err), 0);
    tick();
    rst = 1;

    // Write-back during flush must not raise the error
    sb_if.flush = 1; sb_if.wb_valid = 1; sb_if.wb_rd = 20;
    tick();
    idle();
    #1 chk("fl_wb_no_err", int'(sb_if.wb_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Read-side interlock for the 32x32 register file.
- Tracks destination registers with writes in flight between issue and write-back.
- Stalls the issuing stage while a source operand (rs1/rs2) still has a pending write, so the register-file read ports never return stale data.
- Sits between decode/issue and the write-back path; the write-back path drives the register-file write port and this block's wb_* inputs in the same cycle.

Parameters:
- NUM_REGS, 32, number of architectural registers; index width is 5; register 0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; at most 2^CNT_W-1 outstanding writes per register.
- TOT_W, 7, width of pending_total; must hold 31*(2^CNT_W-1)=93.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  issue stage presents an instruction
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_rd  in  5  destination register
- issue_rd_en  in  1  instruction writes issue_rd
- issue_ready  out  1  instruction accepted this cycle when issue_valid=1
- wb_valid  in  1  write-back retires a write this cycle (same cycle as register-file regWrite)
- wb_rd  in  5  register being written back
- flush  in  1  synchronous clear of all pending state (pipeline flush)
- busy_rs1  out  1  issue_rs1 has a pending write
- busy_rs2  out  1  issue_rs2 has a pending write
- pending_total  out  TOT_W  sum of all per-register counters
- wb_err  out  1  sticky: write-back to a register with counter 0

Behaviour:
- State: cnt[1..31], each CNT_W bits; cnt[0] does not exist and reads as 0.
- Reset (rst=0, asynchronous): all cnt=0, wb_err=0, pending_total=0.
- After reset, issue_ready=1 whenever issue_valid=1 and there is no stall condition.
- busy_rsN = (cnt[issue_rsN] != 0):
  - Combinational from registered counters only.
  - No same-cycle write-back bypass: the register-file data is not written until the clock edge.
  - Index 0 is always not busy.
- sat_rd = issue_rd_en && issue_rd!=0 && cnt[issue_rd]==2^CNT_W-1.
- issue_ready = !(busy_rs1 || busy_rs2 || sat_rd) && !flush. It is independent of issue_valid; issue_valid gates only acceptance.
- accept = issue_valid && issue_ready.
- Per register r (1..31), next-state priority:
  1. flush: cnt=0.
  2. Increment when accept && issue_rd_en && issue_rd==r.
  3. Decrement when wb_valid && wb_rd==r && cnt[r]!=0.
  4. Increment and decrement in the same cycle on the same r: cnt unchanged.
- Write-back with wb_rd==r and cnt[r]==0 (flush not asserted): cnt stays 0 and wb_err is set.
  - Exception: if the same cycle also increments r, the net result is 0->1; decrement is never applied below 0, and wb_err is still set.
- wb_rd==0 or issue_rd==0: no counter change, no error.
- wb_err:
  - Sticky until reset.
  - flush does not clear it.
  - Write-back during flush is ignored and does not set it.
- pending_total: registered; equals the sum of cnt after each edge; updated with the same priority rules; 0 after flush.
- Latency: accepted issue makes busy visible on the next cycle; write-back clears busy on the next cycle.
- Reset mid-operation: all in-flight tracking is discarded immediately, with no dependence on clk.

Test Plan:
- Reset then idle: rst=0 for 2 cycles -> busy_rs1=busy_rs2=0, pending_total=0, wb_err=0; issue_valid=1 with rs1=rs2=rd=0 -> issue_ready=1.
- RAW stall: issue rd=5,rd_en=1 at cycle 0; cycle 1 issue rs1=5 -> busy_rs1=1, issue_ready=0. Cycle 3 wb_valid=1, wb_rd=5 -> cycle 4 busy_rs1=0, issue_ready=1, pending_total=0.
- Saturation: issue rd=7 three times with no write-back -> cnt[7]=3, pending_total=3. Fourth issue rd=7 -> issue_ready=0. One wb_rd=7 -> next cycle issue_ready=1.
- Simultaneous: cnt[9]=1; same cycle accept rd=9 and wb_rd=9 -> cnt[9] stays 1, pending_total unchanged. Also wb_rd=0 and issue_rd=0 -> no change, wb_err=0.
- Error/flush: wb_valid=1, wb_rd=12 with cnt[12]=0 -> wb_err=1 next cycle. Pend rd=3 and rd=4, then flush=1 with wb_rd=3 -> all cnt=0, pending_total=0, wb_err still 1, issue_ready=0 during the flush cycle.
- Async reset mid-flight: pending_total=4, drop rst between clock edges -> outputs cleared before the next rising edge; wb_err=0.
